// File: rtl/qa_strobe_sched.sv
// qa_strobe_sched: settings-bus programmable sample scheduler for the QA datapath.
// It pulls samples from the TX chain (strobe_tx) at a programmed period and burst
// length, forwards each one to the DUT a cycle later (dut_nd/dut_data), and limits
// the number of unanswered samples. It drains at end of burst and exposes
// counters and status for readback.
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   set_stb/set_addr/set_data    settings bus (BASE+0 period, BASE+1 burst, BASE+2 control)
//   tx_run, sample_tx            TX chain run flag and sample
//   strobe_tx                    sample pull pulse to the TX chain
//   dut_data, dut_nd             sample and new-data pulse to the DUT
//   dut_out_nd                   DUT output-valid pulse
//   sent_count, recv_count       delivered samples / DUT outputs since start
//   status                       {24'b0, timeout, overflow, done, busy, 2'b0, state}
module qa_strobe_sched #(
  parameter int unsigned BASE            = 0,
  parameter int unsigned MAX_OUTSTANDING = 16,
  parameter int unsigned DRAIN_TIMEOUT   = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        set_stb,
  input  logic [7:0]  set_addr,
  input  logic [31:0] set_data,
  input  logic        tx_run,
  input  logic [31:0] sample_tx,
  output logic        strobe_tx,
  output logic [31:0] dut_data,
  output logic        dut_nd,
  input  logic        dut_out_nd,
  output logic [31:0] sent_count,
  output logic [31:0] recv_count,
  output logic [31:0] status
);

  localparam int unsigned OW = 8;   // outstanding credit width (MAX_OUTSTANDING <= 255)
  localparam int unsigned DW = 17;  // drain timer width (DRAIN_TIMEOUT <= 2^16)
  localparam int unsigned PW = 16;  // period / divider width
  localparam int unsigned CW = 32;  // counter width

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] period_q, period_n, act_period, act_period_n, divider, divider_n;
  logic [CW-1:0] burst_q, burst_n, act_burst, act_burst_n;
  logic [CW-1:0] issued, issued_n, sent_n, recv_n;
  logic [OW-1:0] outstanding, outstanding_n;
  logic [DW-1:0] drain_cnt, drain_cnt_n;
  logic          overflow, overflow_n, timeout, timeout_n;
  logic [31:0]   status_n;

  logic          ctl_wr, start_acc, stop_acc, burst_hit, issue;
  logic [OW-1:0] out_base, out_after;
  logic [CW-1:0] issued_base;
  logic [PW-1:0] div_base;

  // Sample path to the DUT is a plain wire; dut_nd qualifies it.
  assign dut_data = sample_tx;

  // Next-state, issue decision and counter updates.
  // A start is folded into the same cycle's issue decision (counters and divider
  // seen as cleared) so the first pull follows the start write immediately.
  always_comb begin
    ctl_wr       = set_stb && (set_addr == 8'(BASE + 2));
    start_acc    = ctl_wr && set_data[0] && !set_data[1] && ((state == IDLE) || (state == DONE));
    stop_acc     = ctl_wr && set_data[1] && (state == RUN);
    period_n     = (set_stb && (set_addr == 8'(BASE))) ? set_data[PW-1:0] : period_q;
    burst_n      = (set_stb && (set_addr == 8'(BASE + 1))) ? set_data : burst_q;
    act_period_n = start_acc ? period_q : act_period;
    act_burst_n  = start_acc ? burst_q : act_burst;
    out_base     = start_acc ? '0 : outstanding;
    issued_base  = start_acc ? '0 : issued;
    div_base     = start_acc ? '0 : divider;
    // A response in this cycle frees its credit before the issue check.
    out_after    = out_base - OW'(dut_out_nd && (out_base != '0));
    burst_hit    = (act_burst_n != '0) && (issued_base == act_burst_n);
    issue        = tx_run && (div_base == '0) && (out_after < OW'(MAX_OUTSTANDING)) && !burst_hit
                   && (start_acc || ((state == RUN) && !stop_acc));
    issued_n      = issued_base + CW'(issue);
    outstanding_n = out_after + OW'(issue);
    // Divider holds at zero while issue is stalled.
    divider_n     = issue ? act_period_n : ((div_base != '0) ? div_base - PW'(1) : '0);
    sent_n        = (start_acc ? '0 : sent_count) + CW'(dut_nd);
    recv_n        = (start_acc ? '0 : recv_count) + CW'(dut_out_nd);
    overflow_n    = (overflow && !start_acc) || (dut_out_nd && (out_base == '0));
    timeout_n     = timeout && !start_acc;
    drain_cnt_n   = '0;
    state_n       = state;
    case (state)
      IDLE, DONE: if (start_acc) state_n = RUN;
      RUN:        if (stop_acc || burst_hit) state_n = DRAIN;
      DRAIN: begin
        if (outstanding == '0) begin
          state_n = DONE;
        end else if (drain_cnt == DW'(DRAIN_TIMEOUT - 1)) begin
          state_n   = DONE;
          timeout_n = 1'b1;
        end else begin
          drain_cnt_n = drain_cnt + DW'(1);
        end
      end
      default: state_n = IDLE;
    endcase
    status_n = {24'b0, timeout_n, overflow_n, (state_n == DONE),
                ((state_n == RUN) || (state_n == DRAIN)), 2'b00, state_n};
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      period_q    <= '0;
      burst_q     <= '0;
      act_period  <= '0;
      act_burst   <= '0;
      divider     <= '0;
      issued      <= '0;
      outstanding <= '0;
      drain_cnt   <= '0;
      overflow    <= 1'b0;
      timeout     <= 1'b0;
      strobe_tx   <= 1'b0;
      dut_nd      <= 1'b0;
      sent_count  <= '0;
      recv_count  <= '0;
      status      <= '0;
    end else begin
      state       <= state_n;
      period_q    <= period_n;
      burst_q     <= burst_n;
      act_period  <= act_period_n;
      act_burst   <= act_burst_n;
      divider     <= divider_n;
      issued      <= issued_n;
      outstanding <= outstanding_n;
      drain_cnt   <= drain_cnt_n;
      overflow    <= overflow_n;
      timeout     <= timeout_n;
      strobe_tx   <= issue;
      dut_nd      <= strobe_tx;
      sent_count  <= sent_n;
      recv_count  <= recv_n;
      status      <= status_n;
    end
  end

endmodule

// File: tb/tb_qa_strobe_sched.sv
// tb_qa_strobe_sched: directed bench for qa_strobe_sched with a cycle-level
// reference model (earliest-next-issue time, credit count, drain deadline) and
// literal expectations for the key scenarios.
module tb_qa_strobe_sched;

  localparam int MAXO = 16;
  localparam int DTO  = 4096;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        set_stb = 1'b0;
  logic [7:0]  set_addr = '0;
  logic [31:0] set_data = '0;
  logic        tx_run = 1'b0;
  logic [31:0] sample_tx;
  logic        strobe_tx;
  logic [31:0] dut_data;
  logic        dut_nd;
  logic        dut_out_nd;
  logic [31:0] sent_count;
  logic [31:0] recv_count;
  logic [31:0] status;

  logic echo_en = 1'b0, man_resp = 1'b0;
  logic h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;
  longint cyc = 0;
  int checks = 0, errors = 0;
  longint strobe_q[$];

  qa_strobe_sched #(.BASE(0), .MAX_OUTSTANDING(MAXO), .DRAIN_TIMEOUT(DTO)) dut (
    .clk(clk), .reset_n(reset_n), .set_stb(set_stb), .set_addr(set_addr),
    .set_data(set_data), .tx_run(tx_run), .sample_tx(sample_tx),
    .strobe_tx(strobe_tx), .dut_data(dut_data), .dut_nd(dut_nd),
    .dut_out_nd(dut_out_nd), .sent_count(sent_count), .recv_count(recv_count),
    .status(status)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign sample_tx = 32'hA500_0000 ^ 32'(cyc);

  // Echoing DUT: dut_nd seen in cycle N answers in cycle N+2.
  always @(negedge clk) begin
    h1 <= dut_nd;
    h2 <= h1;
    h3 <= h2;
  end
  assign dut_out_nd = (echo_en & h3) | man_resp;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               nm, act, act, exp, exp, cyc);
    end
  endtask

  // Reference model state
  int          m_mode = 0, m_credit = 0, c0;
  bit          m_strobe = 0, m_nd = 0, m_over = 0, m_tmo = 0, ctl, st, sp, iss;
  logic [31:0] m_sent = '0, m_recv = '0, m_issued = '0, r_burst = '0, a_burst = '0;
  int unsigned r_period = 0, a_period = 0;
  longint      m_t = 0, m_next_ok = 0, m_drain_t0 = 0;

  initial begin : model
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_mode = 0; m_credit = 0; m_strobe = 0; m_nd = 0; m_over = 0; m_tmo = 0;
        m_sent = '0; m_recv = '0; m_issued = '0;
        r_period = 0; r_burst = '0; a_period = 0; a_burst = '0;
      end else begin
        m_t++;
        ctl = set_stb && (set_addr == 8'd2);
        st  = ctl && set_data[0] && !set_data[1] && (m_mode == 0 || m_mode == 3);
        sp  = ctl && set_data[1] && (m_mode == 1);
        c0  = m_credit;
        iss = 0;
        if (st) m_sent = '0;
        if (m_nd) m_sent = m_sent + 32'd1;
        m_nd = m_strobe;
        if (st) begin
          m_issued = '0; m_recv = '0; m_credit = 0; m_over = 0; m_tmo = 0;
          a_period = r_period; a_burst = r_burst; m_next_ok = m_t; m_mode = 1;
        end
        if (dut_out_nd) begin
          m_recv = m_recv + 32'd1;
          if (m_credit == 0) m_over = 1;
          else m_credit--;
        end
        if (m_mode == 1) begin
          if (sp || (a_burst != 0 && m_issued == a_burst)) begin
            m_mode = 2;
            m_drain_t0 = m_t + 1;
          end else if (tx_run && m_t >= m_next_ok && m_credit < MAXO) begin
            iss = 1;
            m_issued = m_issued + 32'd1;
            m_credit++;
            m_next_ok = m_t + longint'(a_period) + 1;
          end
        end else if (m_mode == 2) begin
          if (c0 == 0) m_mode = 3;
          else if (m_t - m_drain_t0 == longint'(DTO - 1)) begin
            m_tmo = 1;
            m_mode = 3;
          end
        end
        m_strobe = iss;
        if (set_stb && set_addr == 8'd0) r_period = int'(set_data[15:0]);
        if (set_stb && set_addr == 8'd1) r_burst = set_data;
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    logic [31:0] es;
    es = {24'b0, m_tmo, m_over, (m_mode == 3), (m_mode == 1 || m_mode == 2), 2'b00, 2'(m_mode)};
    if (strobe_tx) strobe_q.push_back(cyc);
    chk("strobe_tx", longint'(strobe_tx), longint'(m_strobe));
    chk("dut_nd", longint'(dut_nd), longint'(m_nd));
    chk("sent_count", longint'(sent_count), longint'(m_sent));
    chk("recv_count", longint'(recv_count), longint'(m_recv));
    chk("status", longint'(status), longint'(es));
    if (dut_nd) chk("dut_data", longint'(dut_data), longint'(32'hA500_0000 ^ 32'(cyc)));
  end

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    set_stb = 1'b1; set_addr = a; set_data = d;
    @(negedge clk);
    set_stb = 1'b0; set_addr = '0; set_data = '0;
  endtask

  function automatic int count_in(input longint lo, input longint hi);
    int n = 0;
    foreach (strobe_q[i]) if (strobe_q[i] >= lo && strobe_q[i] <= hi) n++;
    return n;
  endfunction

  function automatic longint first_after(input longint t);
    foreach (strobe_q[i]) if (strobe_q[i] > t) return strobe_q[i];
    return -1;
  endfunction

  function automatic longint q_at(input int i);
    if (i < strobe_q.size()) return strobe_q[i];
    return -1;
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin : main
    longint s, g, r;
    int n, qs;
    int t1_exp[4] = '{1, 5, 9, 13};

    #1 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("rst_strobe", longint'(strobe_tx), 0);
    chk("rst_status", longint'(status), 0);
    chk("rst_sent", longint'(sent_count), 0);
    chk("rst_recv", longint'(recv_count), 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Response in IDLE: counted and flagged as overflow, state unchanged.
    @(negedge clk) man_resp = 1'b1;
    @(negedge clk) man_resp = 1'b0;
    @(negedge clk);
    chk("idle_resp_recv", longint'(recv_count), 1);
    chk("idle_resp_status", longint'(status), 32'h40);

    // Start+stop together in IDLE: ignored.
    bus_wr(8'd2, 32'd3);
    @(negedge clk);
    chk("startstop_status", longint'(status), 32'h40);

    // period=3, burst=4, echo after 2 cycles.
    bus_wr(8'd0, 32'd3);
    bus_wr(8'd1, 32'd4);
    tx_run = 1'b1; echo_en = 1'b1;
    strobe_q.delete();
    s = cyc;
    bus_wr(8'd2, 32'd1);
    repeat (30) @(negedge clk);
    chk("t1_nstrobe", strobe_q.size(), 4);
    for (int i = 0; i < 4; i++) chk("t1_strobe_pos", q_at(i) - s, t1_exp[i]);
    chk("t1_status", longint'(status), 32'h23);
    chk("t1_sent", longint'(sent_count), 4);
    chk("t1_recv", longint'(recv_count), 4);

    // tx_run gap of 10 cycles in a 20-sample burst at period 0.
    bus_wr(8'd0, 32'd0);
    bus_wr(8'd1, 32'd20);
    strobe_q.delete();
    s = cyc;
    bus_wr(8'd2, 32'd1);
    repeat (5) @(negedge clk);
    g = cyc;
    tx_run = 1'b0;
    repeat (10) @(negedge clk);
    tx_run = 1'b1;
    repeat (30) @(negedge clk);
    chk("t3_gap_strobes", count_in(g + 1, g + 10), 0);
    chk("t3_before_gap", count_in(s + 1, g), 6);
    chk("t3_resume", first_after(g) - g, 11);
    chk("t3_total", strobe_q.size(), 20);
    chk("t3_status", longint'(status), 32'h23);
    chk("t3_sent", longint'(sent_count), 20);

    // Continuous, silent DUT: credit stall, single credit return, stop, timeout.
    echo_en = 1'b0;
    bus_wr(8'd1, 32'd0);
    strobe_q.delete();
    s = cyc;
    bus_wr(8'd2, 32'd1);
    repeat (20) @(negedge clk);
    chk("t2_nstrobe", strobe_q.size(), 16);
    chk("t2_first", q_at(0) - s, 1);
    chk("t2_last", q_at(15) - s, 16);
    bus_wr(8'd2, 32'd1);
    repeat (2) @(negedge clk);
    chk("t2_restart_sent", longint'(sent_count), 16);
    chk("t2_restart_recv", longint'(recv_count), 0);
    chk("t2_restart_status", longint'(status), 32'h11);
    r = cyc;
    man_resp = 1'b1;
    @(negedge clk) man_resp = 1'b0;
    repeat (4) @(negedge clk);
    chk("t2_credit_strobes", strobe_q.size(), 17);
    chk("t2_credit_pos", q_at(16) - r, 1);
    bus_wr(8'd2, 32'd2);
    chk("t2_drain", longint'(status), 32'h12);
    repeat (DTO - 1) @(negedge clk);
    chk("t2_drain_last", longint'(status), 32'h12);
    @(negedge clk);
    chk("t2_timeout", longint'(status), 32'hA3);
    repeat (3) @(negedge clk);
    chk("t2_no_more", strobe_q.size(), 17);
    chk("t2_sent", longint'(sent_count), 17);
    chk("t2_recv", longint'(recv_count), 1);

    // Asynchronous reset in the middle of a run.
    bus_wr(8'd0, 32'd1);
    bus_wr(8'd1, 32'd0);
    echo_en = 1'b1;
    bus_wr(8'd2, 32'd1);
    n = 0;
    for (int i = 0; i < 40 && n < 5; i++) begin
      @(negedge clk);
      #1;
      if (strobe_tx) n++;
    end
    chk("t6_wait", n, 5);
    echo_en = 1'b0;
    #1 reset_n = 1'b0;
    #1;
    chk("t6_strobe", longint'(strobe_tx), 0);
    chk("t6_nd", longint'(dut_nd), 0);
    chk("t6_status", longint'(status), 0);
    chk("t6_sent", longint'(sent_count), 0);
    chk("t6_recv", longint'(recv_count), 0);
    qs = strobe_q.size();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("t6_no_strobe", strobe_q.size(), qs);
    chk("t6_idle", longint'(status), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/qa_strobe_sched.md
# qa_strobe_sched

Settings-bus-programmable sample scheduler for the QA datapath. It replaces the free-running strobe counter between the TX chain and the `qa_wrapper` under test. It issues sample pulls (`strobe_tx`) toward `vita_tx_chain` at a programmed rate, in a programmed burst length. It forwards each pulled sample to the DUT one cycle later and throttles issue on outstanding-credit. It tracks DUT responses, drains at end of burst and exposes counters and status for readback through `settings_fifo_ctrl`.

## Interface
Parameters:
- `BASE`, 0: first settings-bus address; the block uses BASE+0..BASE+2.
- `MAX_OUTSTANDING`, 16: max issued-but-unanswered samples (1..255).
- `DRAIN_TIMEOUT`, 4096: cycles allowed in DRAIN before abandoning (≥1, ≤2^16).

Ports:
- `clk`  in  1  system clock.
- `reset_n`  in  1  reset; asynchronous, active-low.
- `set_stb`  in  1  settings strobe.
- `set_addr`  in  8  settings address.
- `set_data`  in  32  settings data.
- `tx_run`  in  1  TX chain run; issue gated by it.
- `sample_tx`  in  32  sample from TX chain.
- `strobe_tx`  out  1  pull pulse to TX chain.
- `dut_data`  out  32  sample to DUT; wire of `sample_tx`.
- `dut_nd`  out  1  new-data pulse to DUT.
- `dut_out_nd`  in  1  DUT output-valid pulse.
- `sent_count`  out  32  samples delivered to DUT since start.
- `recv_count`  out  32  DUT outputs since start.
- `status`  out  32  {24'b0, timeout, overflow, done, busy, 2'b0, state[1:0]}.

## Operation
Registers (written when `set_stb` && `set_addr` matches):
- BASE+0 `period[15:0]`.
- BASE+1 `burst[31:0]`; 0 = continuous.
- BASE+2 control: bit0 start, bit1 stop. Self-clearing; no storage.
- `period` and `burst` are reset to 0 and are sampled only at start.

States (`state` encoding): IDLE=0, RUN=1, DRAIN=2, DONE=3.
- IDLE/DONE + start (stop=0):
  - clear `sent_count`, `recv_count`, `issued`, overflow and timeout;
  - load divider=0;
  - go to RUN.
- RUN:
  - Issue condition: divider==0 && `tx_run` && outstanding < MAX_OUTSTANDING, where outstanding = issued − recv_count, saturating at 0.
  - On issue: `strobe_tx`=1, `issued`++, divider←period.
  - Otherwise, if divider≠0: divider−−. If divider==0 but issue is blocked, divider holds at 0 (stall).
  - Exit to DRAIN when `burst`≠0 and `issued`==`burst` after an issue, or on a stop write.
- DRAIN:
  - No issue.
  - Go to DONE when outstanding==0.
  - If DRAIN_TIMEOUT cycles elapse first, set timeout and go to DONE.
- Start in RUN/DRAIN: ignored. Stop in IDLE/DONE: ignored. Start+stop in the same write: stop wins.
- `dut_nd` = registered `strobe_tx`, i.e. high exactly the cycle after each issue. `sent_count`++ on each `dut_nd`.
- `dut_out_nd`: `recv_count`++ in any state.
  - If outstanding==0 at that cycle, set overflow (sticky until next start) and hold outstanding at 0.
  - Responses keep counting in DONE; overflow can also be set there.
- `busy` = state∈{RUN,DRAIN}.
- `done` = state==DONE.
- All counters wrap modulo 2^32.

## Timing
- Reset (`reset_n` low, async): `strobe_tx`=0, `dut_nd`=0, counters=0, `status`=0, state=IDLE, registers=0. Reset mid-burst aborts at once, with no further strobes.
- Start written at cycle S: state=RUN at S+1. First `strobe_tx` at S+1 if `tx_run` and credit are present.
- Issue spacing is period+1 cycles minimum. period=0 gives a strobe every cycle.
- `strobe_tx` at N ⇒ `dut_nd` at N+1, with `dut_data`=`sample_tx` during N+1.
- Credit is evaluated with the `dut_out_nd` of the same cycle already counted: a response in cycle N frees a credit for an issue in cycle N.
- Last issue at cycle L with a burst: DRAIN at L+1. Final `dut_nd` at L+1 still counts.
- Stop at cycle T: no `strobe_tx` at T+1 or later. An issue in cycle T itself still completes its `dut_nd`.
- All outputs are registered except `dut_data`.

## Test plan
- period=3, burst=4, `tx_run`=1, DUT echoes `dut_nd` after 2 cycles:
  - `strobe_tx` at S+1, S+5, S+9, S+13;
  - DONE with `sent_count`=`recv_count`=4, overflow=0, timeout=0.
- period=0, burst=0, MAX_OUTSTANDING=16, DUT silent:
  - exactly 16 consecutive strobes, then a stall;
  - one `dut_out_nd` yields exactly one more strobe in that cycle;
  - stop ⇒ DRAIN, then timeout=1 and DONE after 4096 cycles.
- `tx_run` low for 10 cycles mid-burst: no strobes during the gap; the divider holds at 0; issue resumes the cycle `tx_run` rises.
- `dut_out_nd` in IDLE after reset: `recv_count`=1, overflow=1, state stays IDLE. A subsequent start clears both.
- Same-cycle start+stop write in IDLE: no state change. Start in RUN: counters unchanged.
- Assert `reset_n` low mid-RUN after 5 issues: outputs are 0 immediately (asynchronously); no `dut_nd` follows.
